// File: rtl/seven_seg_driver.sv
// rtl/seven_seg_driver.sv - signed 32-bit value to 8-digit multiplexed seven-segment display driver
module seven_seg_driver #(
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] value,
    output logic        ready,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_COMMIT
    } state_t;

    state_t            state_q, state_d;
    logic              sign_q, sign_d;
    logic              ovf_q, ovf_d;
    logic [23:0]       mag_q, mag_d;
    logic [27:0]       bcd_q, bcd_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [7:0][6:0]   dig_q, dig_d;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [2:0]        idx_q, idx_d;
    logic [7:0]        an_q, an_d;
    logic [6:0]        seg_q, seg_d;

    logic [31:0]       abs_val;
    logic [27:0]       bcd_adj;
    logic [7:0][6:0]   commit_dig;
    logic              lead;

    function automatic logic [6:0] seg_code(input logic [3:0] n);
        case (n)
            4'd0:    seg_code = 7'h40;
            4'd1:    seg_code = 7'h79;
            4'd2:    seg_code = 7'h24;
            4'd3:    seg_code = 7'h30;
            4'd4:    seg_code = 7'h19;
            4'd5:    seg_code = 7'h12;
            4'd6:    seg_code = 7'h02;
            4'd7:    seg_code = 7'h78;
            4'd8:    seg_code = 7'h00;
            4'd9:    seg_code = 7'h10;
            default: seg_code = SEG_BLANK;
        endcase
    endfunction

    // -2^31 negates to itself, which read as unsigned is the required 2^31
    assign abs_val = value[31] ? (~value + 32'd1) : value;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 7; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        commit_dig = {8{SEG_BLANK}};
        lead       = 1'b1;
        if (ovf_q) begin
            commit_dig[7] = SEG_E;
        end else begin
            for (int i = 6; i >= 1; i--) begin
                if (lead && (bcd_q[4*i +: 4] == 4'd0)) begin
                    commit_dig[i] = SEG_BLANK;
                end else begin
                    lead          = 1'b0;
                    commit_dig[i] = seg_code(bcd_q[4*i +: 4]);
                end
            end
            commit_dig[0] = seg_code(bcd_q[3:0]);
            commit_dig[7] = (sign_q && (bcd_q != 28'd0)) ? SEG_DASH : SEG_BLANK;
        end
    end

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        ovf_d   = ovf_q;
        mag_d   = mag_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        dig_d   = dig_q;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    sign_d  = value[31];
                    ovf_d   = (abs_val > 32'd9_999_999);
                    mag_d   = abs_val[23:0];
                    bcd_d   = 28'd0;
                    cnt_d   = 5'd0;
                    state_d = (abs_val > 32'd9_999_999) ? ST_COMMIT : ST_CONV;
                end
            end
            ST_CONV: begin
                bcd_d = {bcd_adj[26:0], mag_q[23]};
                mag_d = {mag_q[22:0], 1'b0};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd23) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                dig_d   = commit_dig;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Scan runs free of the FSM; outputs lag the index by one register stage
    always_comb begin
        pre_d = pre_q + PRE_W'(1);
        idx_d = idx_q;
        if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
            pre_d = '0;
            idx_d = idx_q + 3'd1;
        end
        an_d  = ~(8'd1 << idx_q);
        seg_d = dig_q[idx_q];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            sign_q  <= 1'b0;
            ovf_q   <= 1'b0;
            mag_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            dig_q   <= {{7{SEG_BLANK}}, 7'h40};
            pre_q   <= '0;
            idx_q   <= '0;
            an_q    <= 8'hFF;
            seg_q   <= SEG_BLANK;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            ovf_q   <= ovf_d;
            mag_q   <= mag_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign ready = (state_q == ST_IDLE);
    assign an    = an_q;
    assign seg   = seg_q;
    assign dp    = 1'b1;

endmodule

// File: tb/tb_seven_seg_driver.sv
// tb/tb_seven_seg_driver.sv - self-checking bench for seven_seg_driver
module tb_seven_seg_driver;

    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [31:0] value = 32'd0;
    logic        ready;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int total = 0;
    int bad = 0;

    seven_seg_driver #(.SCAN_DIV(SD)) dut (
        .clk   (clk),
        .rst   (rst_n),
        .load  (load),
        .value (value),
        .ready (ready),
        .an    (an),
        .seg   (seg),
        .dp    (dp)
    );

    always #5 clk = ~clk;

    localparam logic [7:0][6:0] RST_DISP = {{7{7'h7F}}, 7'h40};

    function automatic logic [6:0] code_of(input int d);
        logic [6:0] tbl [10];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return tbl[d];
    endfunction

    function automatic longint mag_of(input logic [31:0] v);
        longint m;
        m = longint'($signed(v));
        if (m < 0) m = -m;
        return m;
    endfunction

    function automatic bit ovf_of(input logic [31:0] v);
        return mag_of(v) > 64'd9_999_999;
    endfunction

    // Decimal rendering straight from integer arithmetic
    function automatic logic [7:0][6:0] disp_of(input logic [31:0] v);
        logic [7:0][6:0] d;
        longint m;
        longint p;
        m = mag_of(v);
        d = {8{7'h7F}};
        if (m > 64'd9_999_999) begin
            d[7] = 7'h06;
        end else begin
            p = 1;
            for (int i = 0; i < 7; i++) begin
                if (i == 0 || m >= p) d[i] = code_of(int'((m / p) % 10));
                p = p * 10;
            end
            if (v[31] && m != 0) d[7] = 7'h3F;
        end
        return d;
    endfunction

    // Model: edge count since reset release, busy countdown to commit
    int              e = 0;
    int              busy = 0;
    logic [7:0][6:0] disp = RST_DISP;
    logic [7:0][6:0] pend = RST_DISP;
    logic [7:0]      exp_an = 8'hFF;
    logic [6:0]      exp_seg = 7'h7F;
    logic            exp_ready = 1'b1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e         <= 0;
            busy      <= 0;
            disp      <= RST_DISP;
            exp_an    <= 8'hFF;
            exp_seg   <= 7'h7F;
            exp_ready <= 1'b1;
        end else begin
            e       <= e + 1;
            exp_an  <= ~(8'd1 << ((e / SD) % 8));
            exp_seg <= disp[(e / SD) % 8];
            if (busy > 0) begin
                busy      <= busy - 1;
                exp_ready <= (busy == 1);
                if (busy == 1) disp <= pend;
            end else if (load) begin
                pend      <= disp_of(value);
                busy      <= ovf_of(value) ? 1 : 25;
                exp_ready <= 1'b0;
            end else begin
                exp_ready <= 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic show_check(input string name, input int idx, input logic [6:0] lit);
        logic [7:0] want;
        bit found;
        want = ~(8'd1 << idx);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (an === want) found = 1;
        end
        if (!found) check({name, "_scan_timeout"}, {24'd0, an}, {24'd0, want});
        else check(name, {25'd0, seg}, {25'd0, lit});
    endtask

    task automatic do_load(input string name, input logic [31:0] v, input int exp_low);
        int n;
        @(negedge clk);
        load  = 1'b1;
        value = v;
        n = 0;
        @(negedge clk);
        load = 1'b0;
        while (!ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        check({name, "_busy_cycles"}, n, exp_low);
        repeat (36) @(negedge clk);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    check("rst_ready", {31'd0, ready}, 32'd1);
                    check("rst_an", {24'd0, an}, 32'hFF);
                    check("rst_seg", {25'd0, seg}, 32'h7F);
                end else if (e > 0) begin
                    check("ready", {31'd0, ready}, {31'd0, exp_ready});
                    check("an", {24'd0, an}, {24'd0, exp_an});
                    check("seg", {25'd0, seg}, {25'd0, exp_seg});
                    check("dp", {31'd0, dp}, 32'd1);
                end
            end
        join_none

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("first_an", {24'd0, an}, 32'hFE);
        check("first_seg", {25'd0, seg}, 32'h40);
        repeat (34) @(negedge clk);

        do_load("v1234", 32'd1234, 25);
        show_check("v1234_d3", 3, 7'h79);
        show_check("v1234_d0", 0, 7'h19);
        show_check("v1234_d4", 4, 7'h7F);

        do_load("vm56", -32'sd56, 25);
        show_check("vm56_d7", 7, 7'h3F);
        show_check("vm56_d1", 1, 7'h12);
        show_check("vm56_d0", 0, 7'h02);

        do_load("v0", 32'd0, 25);
        show_check("v0_d0", 0, 7'h40);
        show_check("v0_d7", 7, 7'h7F);

        do_load("v9999999", 32'd9_999_999, 25);
        show_check("v9999999_d6", 6, 7'h10);
        show_check("v9999999_d7", 7, 7'h7F);

        do_load("v10000000", 32'd10_000_000, 1);
        show_check("v10000000_d7", 7, 7'h06);
        show_check("v10000000_d0", 0, 7'h7F);

        do_load("vmin", 32'h8000_0000, 1);
        show_check("vmin_d7", 7, 7'h06);

        do_load("vm9999999", -32'sd9_999_999, 25);
        show_check("vm9999999_d7", 7, 7'h3F);

        @(negedge clk);
        load  = 1'b1;
        value = 32'd42;
        @(negedge clk);
        load = 1'b0;
        repeat (4) @(negedge clk);
        load  = 1'b1;
        value = 32'd7;
        @(negedge clk);
        load = 1'b0;
        repeat (60) @(negedge clk);
        show_check("v42_d1", 1, 7'h19);
        show_check("v42_d0", 0, 7'h24);

        @(negedge clk);
        load  = 1'b1;
        value = 32'd5555;
        @(negedge clk);
        load = 1'b0;
        repeat (9) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("abort_ready", {31'd0, ready}, 32'd1);
        check("abort_an", {24'd0, an}, 32'hFF);
        check("abort_seg", {25'd0, seg}, 32'h7F);
        check("abort_dp", {31'd0, dp}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (36) @(negedge clk);
        show_check("abort_d0", 0, 7'h40);
        show_check("abort_d3", 3, 7'h7F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
